// File: rtl/multdiv32.sv
// Iterative 32-bit radix-2 multiply / restoring divide producing HI/LO; MULTDIV_SIGNED_EN selects signed mult/div.
// Latency: 32 cycles from the accepting edge to hi/lo update with a one-cycle done pulse.
// Backpressure: none; start is only sampled in IDLE and busy tells control to stall.
module multdiv32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
`ifdef MULTDIV_SIGNED_EN
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               sign_a, sign_b;
`endif

    logic               legal;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] iter_acc;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign legal = start && (funct[5:2] == 4'b0110);

`ifdef MULTDIV_SIGNED_EN
    // funct[0] clear selects the signed variants (mult/div)
    assign sign_a = ~funct[0] & operand_a[WIDTH-1];
    assign sign_b = ~funct[0] & operand_b[WIDTH-1];
    assign mag_a  = sign_a ? -operand_a : operand_a;
    assign mag_b  = sign_b ? -operand_b : operand_b;
`else
    assign mag_a  = operand_a;
    assign mag_b  = operand_b;
`endif

    // Multiply: acc holds the product, shifted right with the adder carry on top.
    // Divide:   acc holds {remainder, quotient}; dividend bits are fed from opa MSB.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : '0);
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
    assign div_ok    = div_shift >= {1'b0, opb_q};
    assign div_rem   = div_ok ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];

    always_comb begin
        iter_acc = {mul_sum, acc_q[WIDTH-1:1]};
        if (is_div_q) begin
            iter_acc = {div_rem, acc_q[WIDTH-2:0], div_ok};
        end
    end

    always_comb begin
        res_hi = iter_acc[2*WIDTH-1:WIDTH];
        res_lo = iter_acc[WIDTH-1:0];
`ifdef MULTDIV_SIGNED_EN
        if (is_div_q) begin
            if (neg_q)  res_lo = -iter_acc[WIDTH-1:0];
            if (rneg_q) res_hi = -iter_acc[2*WIDTH-1:WIDTH];
        end else if (neg_q) begin
            {res_hi, res_lo} = -iter_acc;
        end
`endif
        // Remainder already equals the dividend here; force the quotient pattern
        if (is_div_q && div0_q) begin
            res_lo = '1;
        end
    end

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULTDIV_SIGNED_EN
        neg_d    = neg_q;
        rneg_d   = rneg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (legal) begin
                    state_d  = S_RUN;
                    opa_d    = mag_a;
                    opb_d    = mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    is_div_d = funct[1];
                    div0_d   = (operand_b == '0);
`ifdef MULTDIV_SIGNED_EN
                    neg_d    = sign_a ^ sign_b;
                    rneg_d   = sign_a;
`endif
                end
            end
            S_RUN: begin
                acc_d = iter_acc;
                cnt_d = cnt_q + 6'd1;
                if (is_div_q) begin
                    opa_d = {opa_q[WIDTH-2:0], 1'b0};
                end else begin
                    opb_d = {1'b0, opb_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULTDIV_SIGNED_EN
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
`endif
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == S_RUN);
    assign done = done_q;

endmodule

// File: tb/tb_multdiv32.sv
// Directed-vector bench for multdiv32: timing, unsigned/signed results, ignored starts, mid-op reset.
module tb_multdiv32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

`ifdef MULTDIV_SIGNED_EN
    localparam logic [31:0] MUL_N3X5_HI = 32'hFFFFFFFF;
    localparam logic [31:0] MUL_N3X5_LO = 32'hFFFFFFF1;
    localparam logic [31:0] DIV_N7D2_HI = 32'hFFFFFFFF;
    localparam logic [31:0] DIV_N7D2_LO = 32'hFFFFFFFD;
    localparam logic [31:0] DIV_MIN_HI  = 32'h00000000;
    localparam logic [31:0] DIV_MIN_LO  = 32'h80000000;
`else
    localparam logic [31:0] MUL_N3X5_HI = 32'h00000004;
    localparam logic [31:0] MUL_N3X5_LO = 32'hFFFFFFF1;
    localparam logic [31:0] DIV_N7D2_HI = 32'h00000001;
    localparam logic [31:0] DIV_N7D2_LO = 32'h7FFFFFFC;
    localparam logic [31:0] DIV_MIN_HI  = 32'h80000000;
    localparam logic [31:0] DIV_MIN_LO  = 32'h00000000;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    multdiv32 dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .funct     (funct),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one op and checks busy/done timing and the result; poke injects a
    // second start (different operands) ten cycles into the run.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit poke);
        int busy_n = 0;
        int done_n = 0;
        @(negedge clock);
        start = 1'b1; funct = f; operand_a = a; operand_b = b;
        @(posedge clock);
        #1 start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            if (busy) busy_n++;
            if (done) done_n++;
            if (poke && i == 9) begin
                start = 1'b1; funct = F_DIVU; operand_a = 32'd1000; operand_b = 32'd3;
            end
            if (poke && i == 10) start = 1'b0;
        end
        check({tag, " busy_cycles"}, 64'(busy_n), 64'd32);
        check({tag, " early_done"}, 64'(done_n), 64'd0);
        @(negedge clock);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " busy_end"}, {63'd0, busy}, 64'd0);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        @(negedge clock);
        check({tag, " done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, " hold"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int busy_n;
        int done_n;
        reset = 1'b1; start = 1'b0; funct = '0; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        reset = 1'b0;

        run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);

        // Illegal funct must not start anything
        @(negedge clock);
        start = 1'b1; funct = 6'b100000; operand_a = 32'd9; operand_b = 32'd9;
        @(posedge clock);
        #1 start = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (busy) busy_n++;
        end
        check("illegal busy", 64'(busy_n), 64'd0);
        check("illegal hold", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});

        run_op("divu_100_7_poke", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        run_op("divu_5_0", F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0);
        run_op("divu_7_100", F_DIVU, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0);
        run_op("multu_shift", F_MULTU, 32'h00010000, 32'h00030000, 32'd3, 32'd0, 1'b0);
        run_op("mult_n3x5", F_MULT, 32'hFFFFFFFD, 32'd5, MUL_N3X5_HI, MUL_N3X5_LO, 1'b0);
        run_op("div_n7d2", F_DIV, 32'hFFFFFFF9, 32'd2, DIV_N7D2_HI, DIV_N7D2_LO, 1'b0);
        run_op("div_min", F_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_MIN_HI, DIV_MIN_LO, 1'b0);
        run_op("div_n5_0", F_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);

        // Reset in the middle of a divide aborts it without a done pulse
        @(negedge clock);
        start = 1'b1; funct = F_DIVU; operand_a = 32'd100; operand_b = 32'd7;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (15) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) done_n++;
        end
        check("abort no_done", 64'(done_n), 64'd0);

        run_op("multu_after_reset", F_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/multdiv32.md
# multdiv32

Iterative 32-bit multiply/divide unit for the MIPS core, producing the HI/LO pair that the decode/register-file stage latches on multiply/divide instructions and returns through mfhi/mflo. It sits beside the ALU in the execute stage, takes its operands from the register-file read ports, and runs a radix-2 shift-add multiply or restoring divide over 32 cycles. A busy/done handshake lets the control unit stall the pipeline until the result is valid.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clock  input  1  single system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- funct  input  6  Instruction[5:0]: 011000 mult, 011001 multu, 011010 div, 011011 divu.
- operand_a  input  32  rs value (multiplicand / dividend).
- operand_b  input  32  rt value (multiplier / divisor).
- hi  output  32  mult: product[63:32]; div: remainder.
- lo  output  32  mult: product[31:0]; div: quotient.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when hi/lo have just been updated.

## Operation
- States: IDLE, RUN.
- IDLE: if start=1 and funct is one of the four legal codes, latch operand_a, operand_b, funct and the operand signs, clear the 64-bit accumulator and 6-bit iteration counter, go to RUN. start with any other funct is ignored (stay IDLE, busy stays 0).
- start while in RUN is ignored; operands are not re-sampled.
- RUN, multiply: each cycle, if multiplier LSB=1 add multiplicand into accumulator upper half; shift {carry, accumulator} right by 1. 32 iterations.
- RUN, divide: restoring; each cycle shift {remainder, quotient} left by 1, trial-subtract divisor from remainder (33-bit), keep result and set quotient LSB if non-negative. 32 iterations.
- On the 32nd iteration: write hi/lo, pulse done, return to IDLE.
- Divide by zero (unsigned): hi = operand_a, lo = 32'hFFFFFFFF; no exception, same latency.
- hi/lo hold their value between operations; only a completed operation or reset changes them.
- Arithmetic: multiply result is the full 64 bits, no truncation; quotient/remainder satisfy a = q*b + r with |r| < |b| for b≠0.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- start accepted at edge N -> busy=1 from after edge N through edge N+31 inclusive; hi/lo updated and done=1 after edge N+32; busy=0 in that same cycle.
- Latency: 32 cycles from accepting edge to result, independent of operand values and funct.
- New start may be accepted at edge N+33 (the cycle done is high); back-to-back throughput one op per 33 cycles.
- reset asserted at any edge, including mid-RUN, aborts the operation: all outputs return to reset values the following cycle, no done pulse.
- start and reset in the same cycle: reset wins.

## Configuration
- MULTDIV_SIGNED_EN defined: mult and div are signed. Operands converted to magnitudes at start; at completion, product negated if signs differ; quotient negated if signs differ; remainder takes dividend's sign. Signed divide by zero: hi = operand_a, lo = 32'hFFFFFFFF. 32'h80000000 / 32'hFFFFFFFF gives lo = 32'h80000000, hi = 0.
- Not defined: mult behaves exactly as multu and div exactly as divu; sign logic absent.

## Test plan
- multu 32'hFFFFFFFF x 32'hFFFFFFFF -> after 32 cycles hi=32'hFFFFFFFE, lo=32'h00000001, done pulses one cycle, busy high 32 cycles.
- divu 100 / 7 -> lo=14, hi=2; divu 5 / 0 -> lo=32'hFFFFFFFF, hi=5.
- With MULTDIV_SIGNED_EN: mult -3 x 5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; div -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; without macro, div 32'hFFFFFFF9 / 2 -> lo=32'h7FFFFFFC, hi=1.
- Second start with different operands at cycle 10 of a running op -> ignored; result matches first operands; start with funct 100000 in IDLE -> busy stays 0.
- reset asserted at cycle 16 of a divide -> next cycle hi=lo=0, busy=0, done never pulses; fresh op afterwards completes correctly.
